reorder_buffer: RTL



---
 rtl/reorder_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, records FU completions, retires up to two done entries per cycle.
// Latency: completion at edge N retires in cycle N+1 at the earliest; alloc-to-retire is at least 2 cycles.
// Backpressure: alloc_ready drops while all DEPTH entries are held (registered count only); retire is never stalled.
module reorder_buffer #(
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd_arch,
    input  logic [PREG_W-1:0] alloc_rd_phys,
    input  logic [PREG_W-1:0] alloc_old_phys,
    input  logic              alloc_reg_write,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_rob_num,
    input  logic              complete_valid_0,
    input  logic [IDX_W-1:0]  complete_rob_0,
    input  logic [31:0]       complete_value_0,
    input  logic              complete_valid_1,
    input  logic [IDX_W-1:0]  complete_rob_1,
    input  logic [31:0]       complete_value_1,
    input  logic              complete_valid_2,
    input  logic [IDX_W-1:0]  complete_rob_2,
    input  logic [31:0]       complete_value_2,
    output logic              retire_valid_0,
    output logic [4:0]        retire_arch_rd_0,
    output logic [PREG_W-1:0] retire_phys_rd_0,
    output logic [PREG_W-1:0] retire_old_phys_0,
    output logic [31:0]       retire_value_0,
    output logic              retire_reg_write_0,
    output logic              retire_valid_1,
    output logic [4:0]        retire_arch_rd_1,
    output logic [PREG_W-1:0] retire_phys_rd_1,
    output logic [PREG_W-1:0] retire_old_phys_1,
    output logic [31:0]       retire_value_1,
    output logic              retire_reg_write_1,
    output logic [IDX_W:0]    count,
    output logic              empty
);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, done_q, rw_q;
    logic [4:0]        arch_q  [DEPTH];
    logic [PREG_W-1:0] phys_q  [DEPTH];
    logic [PREG_W-1:0] old_q   [DEPTH];
    logic [31:0]       value_q [DEPTH];
    logic [IDX_W-1:0]  head_q, tail_q, head1;
    logic [IDX_W:0]    count_q;

    logic              alloc_fire, ret0, ret1;
    logic [1:0]        ret_cnt;
    logic              cv   [3];
    logic [IDX_W-1:0]  crob [3];
    logic [31:0]       cval [3];

    assign cv   = '{complete_valid_0, complete_valid_1, complete_valid_2};
    assign crob = '{complete_rob_0, complete_rob_1, complete_rob_2};
    assign cval = '{complete_value_0, complete_value_1, complete_value_2};

    assign head1         = head_q + IDX_W'(1);
    assign alloc_ready   = count_q < DEPTH_C;
    assign alloc_rob_num = tail_q;
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign ret0          = valid_q[head_q] && done_q[head_q];
    assign ret1          = ret0 && valid_q[head1] && done_q[head1];
    assign ret_cnt       = {1'b0, ret0} + {1'b0, ret1};
    assign count         = count_q;
    assign empty         = (count_q == '0);

    always_comb begin
        retire_valid_0     = ret0;
        retire_arch_rd_0   = '0;
        retire_phys_rd_0   = '0;
        retire_old_phys_0  = '0;
        retire_value_0     = '0;
        retire_reg_write_0 = 1'b0;
        retire_valid_1     = ret1;
        retire_arch_rd_1   = '0;
        retire_phys_rd_1   = '0;
        retire_old_phys_1  = '0;
        retire_value_1     = '0;
        retire_reg_write_1 = 1'b0;
        if (ret0) begin
            retire_arch_rd_0   = arch_q[head_q];
            retire_phys_rd_0   = phys_q[head_q];
            retire_old_phys_0  = old_q[head_q];
            retire_value_0     = value_q[head_q];
            retire_reg_write_0 = rw_q[head_q];
        end
        if (ret1) begin
            retire_arch_rd_1   = arch_q[head1];
            retire_phys_rd_1   = phys_q[head1];
            retire_old_phys_1  = old_q[head1];
            retire_value_1     = value_q[head1];
            retire_reg_write_1 = rw_q[head1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Lanes walked high to low so the lowest lane's value lands last and wins.
            for (int k = 2; k >= 0; k--) begin
                if (cv[k] && valid_q[crob[k]]) begin
                    done_q[crob[k]]  <= 1'b1;
                    value_q[crob[k]] <= cval[k];
                end
            end
            if (ret0) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (ret1) begin
                valid_q[head1] <= 1'b0;
                done_q[head1]  <= 1'b0;
            end
            // Tail is never a retiring entry when allocation fires, so this cannot collide.
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                arch_q[tail_q]  <= alloc_rd_arch;
                phys_q[tail_q]  <= alloc_rd_phys;
                old_q[tail_q]   <= alloc_old_phys;
                rw_q[tail_q]    <= alloc_reg_write;
                tail_q          <= tail_q + IDX_W'(1);
            end
            head_q  <= head_q + IDX_W'(ret_cnt);
            count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(ret_cnt);
        end
    end
endmodule
